// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer type, depth and Gray/binary conversion helpers.
package fifo_pkg;

   localparam int FIFO_ADDR_WIDTH = 3;
   localparam int DEPTH           = 2 ** FIFO_ADDR_WIDTH;

   // Widest pointer the helpers handle; callers cast the result to their own width.
   localparam int FN_W = 32;

   typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

   // Gray encode: works for any width because the unused upper bits are zero.
   function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray decode of the low w bits: XOR prefix running down from bit w-1.
   function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g, input int w);
      logic [FN_W-1:0] b;
      b = '0;
      for (int i = FN_W - 1; i >= 0; i--) begin
         if (i >= w) begin
            b[i] = 1'b0;
         end else if (i == w - 1) begin
            b[i] = g[i];
         end else begin
            b[i] = b[i+1] ^ g[i];
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/ptr_sync.sv
// N-stage flop chain that carries a Gray pointer bus into the local clock domain.
// Shared by the write-side and read-side pointer managers.
module ptr_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_r [STAGES];

   // Plain shift chain: nothing but wire between consecutive stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_r[i] <= '0;
         end
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign q = stage_r[STAGES-1];

endmodule

// File: rtl/fifo_wr_ptr_gray.sv
// Write-side pointer manager of the async FIFO: binary write pointer, registered
// Gray copy for the read domain, synchronized read pointer, full/level/overflow.
module fifo_wr_ptr_gray
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH  = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [ADDR_WIDTH:0]   rptr_gray,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   wptr_gray,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  overflow
);

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] wbin_r;
   logic [PW-1:0] wgray_r;
   logic          full_r;
   logic [PW-1:0] level_r;
   logic          overflow_r;

   logic [PW-1:0] rq_gray_s;
   logic [PW-1:0] rbin_sync_s;
   logic          accept_s;
   logic [PW-1:0] wbin_next_s;
   logic [PW-1:0] wgray_next_s;
   logic [PW-1:0] full_match_s;

   ptr_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .clk (clk),
      .rst (rst),
      .d   (rptr_gray),
      .q   (rq_gray_s)
   );

   // Next-pointer logic; the synced read pointer is the only view of the read side.
   always_comb begin
      accept_s = push & ~full_r;
      if (accept_s) begin
         wbin_next_s = wbin_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         wbin_next_s = wbin_r;
      end
      wgray_next_s = PW'(bin2gray(FN_W'(wbin_next_s)));
      rbin_sync_s  = PW'(gray2bin(FN_W'(rq_gray_s), PW));
      // Full when write Gray equals read Gray with the top two bits inverted.
      full_match_s = {~rq_gray_s[PW-1:PW-2], rq_gray_s[PW-3:0]};
   end

   // Pointer and status registers; full is computed from the next pointer so it
   // asserts in the same cycle the last slot is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbin_r     <= '0;
         wgray_r    <= '0;
         full_r     <= 1'b0;
         level_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         wbin_r     <= wbin_next_s;
         wgray_r    <= wgray_next_s;
         full_r     <= (wgray_next_s == full_match_s);
         level_r    <= wbin_next_s - rbin_sync_s;
         overflow_r <= push & full_r;
      end
   end

   assign wr_en     = accept_s;
   assign wr_addr   = wbin_r[ADDR_WIDTH-1:0];
   assign wptr_gray = wgray_r;
   assign full      = full_r;
   assign wr_level  = level_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_fifo_wr_ptr_gray.sv
// Directed and randomized checks of the async-FIFO write pointer manager (A=3, 2 sync stages).
module tb_fifo_wr_ptr_gray;
   import fifo_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       push;
   ptr_t       rptr_gray;
   logic       wr_en;
   logic [2:0] wr_addr;
   ptr_t       wptr_gray;
   logic       full;
   ptr_t       wr_level;
   logic       overflow;

   int tests = 0;
   int fails = 0;

   fifo_wr_ptr_gray #(.ADDR_WIDTH(3), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .rptr_gray (rptr_gray),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wptr_gray (wptr_gray),
      .full      (full),
      .wr_level  (wr_level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] g4(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [3:0] exp_gray [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100};
   logic [3:0] prev_g;
   logic [3:0] wb;
   logic [3:0] mw, mr, ms0, ms1, mlev;
   logic       mfull, movf, p;

   initial begin
      // Reset state
      rst = 1'b1; push = 1'b0; rptr_gray = 4'b0000;
      #1;
      chk("rst_wptr", wptr_gray, 4'b0000);
      chk("rst_full", full, 1'b0);
      chk("rst_level", wr_level, 4'd0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_addr", wr_addr, 3'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Eight pushes with read pointer at 0: fills the FIFO
      for (int i = 0; i < 8; i++) begin
         push = 1'b1;
         #1;
         chk("fill_wren", wr_en, 1'b1);
         chk("fill_addr", wr_addr, i[2:0]);
         step();
         chk("fill_gray", wptr_gray, exp_gray[i]);
         chk("fill_level", wr_level, i[3:0] + 4'd1);
         chk("fill_full", full, (i == 7) ? 1'b1 : 1'b0);
      end

      // Ninth push while full is dropped
      #1;
      chk("ovf_wren", wr_en, 1'b0);
      step();
      chk("ovf_pulse", overflow, 1'b1);
      chk("ovf_gray", wptr_gray, 4'b1100);
      chk("ovf_addr", wr_addr, 3'd0);
      push = 1'b0;
      step();
      chk("ovf_clear", overflow, 1'b0);
      chk("ovf_full", full, 1'b1);

      // One read: full drops SYNC_STAGES+1 edges later
      rptr_gray = 4'b0001;
      step();
      chk("rd_full_e1", full, 1'b1);
      step();
      chk("rd_full_e2", full, 1'b1);
      step();
      chk("rd_full_e3", full, 1'b0);
      chk("rd_level", wr_level, 4'd7);

      // Drain, then 20 push/read pairs at full rate across the wrap
      rptr_gray = g4(4'd8);
      step(); step(); step();
      chk("drain_level", wr_level, 4'd0);
      chk("drain_full", full, 1'b0);
      for (int k = 0; k < 20; k++) begin
         wb = 4'(8 + k);
         push = 1'b1;
         rptr_gray = g4(wb);
         #1;
         chk("wrap_addr", wr_addr, 32'(wb[2:0]));
         chk("wrap_wren", wr_en, 1'b1);
         prev_g = wptr_gray;
         step();
         chk("wrap_ham", $countones(prev_g ^ wptr_gray), 32'd1);
         chk("wrap_gray", wptr_gray, g4(wb + 4'd1));
      end
      push = 1'b0;
      rptr_gray = g4(4'd12);
      step(); step(); step();
      chk("wrap_level", wr_level, 4'd0);

      // Push with a simultaneous read-pointer change: old view for SYNC_STAGES cycles
      for (int k = 0; k < 7; k++) begin
         push = 1'b1;
         step();
      end
      chk("sim_pre_level", wr_level, 4'd7);
      chk("sim_pre_full", full, 1'b0);
      push = 1'b1;
      rptr_gray = g4(4'd13);
      step();
      chk("sim_gray", wptr_gray, 4'b0110);
      chk("sim_full_c1", full, 1'b1);
      chk("sim_level_c1", wr_level, 4'd8);
      push = 1'b0;
      step();
      chk("sim_full_c2", full, 1'b1);
      chk("sim_level_c2", wr_level, 4'd8);
      chk("sim_gray_c2", wptr_gray, 4'b0110);
      step();
      chk("sim_full_c3", full, 1'b0);
      chk("sim_level_c3", wr_level, 4'd7);

      // Reach wbin=5 then reset mid-burst
      push = 1'b1;
      #1;
      chk("mid_addr", wr_addr, 3'd4);
      step();
      chk("mid_gray", wptr_gray, 4'b0111);
      chk("mid_addr5", wr_addr, 3'd5);
      #3;
      rst = 1'b1; push = 1'b0; rptr_gray = 4'b0000;
      #1;
      chk("arst_wptr", wptr_gray, 4'b0000);
      chk("arst_addr", wr_addr, 3'd0);
      chk("arst_full", full, 1'b0);
      chk("arst_level", wr_level, 4'd0);
      chk("arst_ovf", overflow, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step();
      push = 1'b1;
      #1;
      chk("post_addr", wr_addr, 3'd0);
      chk("post_wren", wr_en, 1'b1);
      step();
      chk("post_gray", wptr_gray, 4'b0001);

      // Random pushes and read advances against a reference model
      mw = 4'd1; mr = 4'd0; ms0 = 4'd0; ms1 = 4'd0; mfull = 1'b0;
      for (int n = 0; n < 300; n++) begin
         p = 1'($urandom_range(0, 1));
         if (mr != mw && $urandom_range(0, 1) == 1) begin
            mr = mr + 4'd1;
         end
         push = p;
         rptr_gray = g4(mr);
         #1;
         chk("rnd_wren", wr_en, p & ~mfull);
         @(posedge clk);
         movf = p & mfull;
         if (p & ~mfull) begin
            mw = mw + 4'd1;
         end
         mlev  = mw - ms1;
         mfull = (mlev == 4'd8);
         ms1 = ms0;
         ms0 = mr;
         #1;
         chk("rnd_full", full, mfull);
         chk("rnd_ovf", overflow, movf);
         chk("rnd_level", wr_level, mlev);
         chk("rnd_gray", wptr_gray, g4(mw));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
